// File: rtl/conv1d_host_pkg.sv
// Shared definitions for the conv1d host sequencer: FSM state encoding and the
// default memory map that the accelerator datapath also uses.
package conv1d_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT_RUN,
    ST_WAIT_DONE,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_RD_OUT,
    ST_FINISH
  } state_t;

  localparam int MEM_DATA_W   = 32;
  localparam int MEM_ADDR_W   = 10;
  localparam int MEM_KER_LEN  = 20;
  localparam int MEM_IN_LEN   = 147;
  localparam int MEM_OUT_LEN  = 128;
  localparam int MEM_KER_BASE = 0;
  localparam int MEM_IN_BASE  = 32;
  localparam int MEM_OUT_BASE = 512;
  localparam int MEM_TIMEOUT  = 4096;

endpackage

// File: rtl/conv1d_host_seq.sv
// Host-side sequencer: loads kernel/input words through the external memory port,
// kicks the conv1d accelerator, then streams the output region back to the MCU.
module conv1d_host_seq
  import conv1d_host_pkg::*;
#(
  parameter int DATA_W   = MEM_DATA_W,
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int KER_LEN  = MEM_KER_LEN,
  parameter int IN_LEN   = MEM_IN_LEN,
  parameter int OUT_LEN  = MEM_OUT_LEN,
  parameter int KER_BASE = MEM_KER_BASE,
  parameter int IN_BASE  = MEM_IN_BASE,
  parameter int OUT_BASE = MEM_OUT_BASE,
  parameter int TIMEOUT  = MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_start,
  output logic              o_busy,
  output logic              o_job_done,
  output logic              o_error,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_acc_start,
  input  logic              i_acc_running,
  input  logic              i_acc_done,
  input  logic              i_acc_ext_sel,
  output logic              o_ext_req,
  output logic              o_ext_we,
  output logic [ADDR_W-1:0] o_ext_addr,
  output logic [DATA_W-1:0] o_ext_wdata,
  input  logic [DATA_W-1:0] i_ext_rdata
);

  localparam int NWORDS = KER_LEN + IN_LEN;
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int KCNT_W = $clog2(OUT_LEN + 1);

  state_t              r_state, w_next;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [KCNT_W-1:0]   r_k;
  logic [DATA_W-1:0]   r_res_data;
  logic                r_error;

  logic                w_ld_fire, w_last_word, w_done_ok, w_timeout, w_last_res;
  logic [ADDR_W-1:0]   w_ld_addr, w_rd_addr;

  assign w_ld_fire   = (r_state == ST_LOAD) && i_ld_valid && i_acc_ext_sel;
  assign w_last_word = (r_wcnt == WCNT_W'(NWORDS - 1));
  // Done is only trusted once running has dropped and the memory is ours again;
  // a stale done from the previous job is filtered by passing WAIT_RUN first.
  assign w_done_ok   = i_acc_done && !i_acc_running && i_acc_ext_sel;
  assign w_timeout   = (r_tcnt == TCNT_W'(TIMEOUT - 1)) &&
                       (((r_state == ST_WAIT_RUN) && !i_acc_running) ||
                        ((r_state == ST_WAIT_DONE) && !w_done_ok));
  assign w_last_res  = (r_k == KCNT_W'(OUT_LEN - 1));

  assign w_ld_addr = (r_wcnt < WCNT_W'(KER_LEN))
                   ? ADDR_W'(KER_BASE) + ADDR_W'(r_wcnt)
                   : ADDR_W'(IN_BASE) + ADDR_W'(r_wcnt) - ADDR_W'(KER_LEN);
  assign w_rd_addr = ADDR_W'(OUT_BASE) + ADDR_W'(r_k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (i_cmd_start) w_next = ST_LOAD;
      ST_LOAD:      if (w_ld_fire && w_last_word) w_next = ST_KICK;
      ST_KICK:      w_next = ST_WAIT_RUN;
      ST_WAIT_RUN:  if (i_acc_running) w_next = ST_WAIT_DONE;
                    else if (w_timeout) w_next = ST_IDLE;
      ST_WAIT_DONE: if (w_done_ok) w_next = ST_RD_REQ;
                    else if (w_timeout) w_next = ST_IDLE;
      ST_RD_REQ:    if (i_acc_ext_sel) w_next = ST_RD_CAP;
      ST_RD_CAP:    w_next = ST_RD_OUT;
      ST_RD_OUT:    if (i_res_ready) w_next = w_last_res ? ST_FINISH : ST_RD_REQ;
      ST_FINISH:    w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != ST_IDLE);
    o_job_done  = 1'b0;
    o_ld_ready  = 1'b0;
    o_res_valid = 1'b0;
    o_acc_start = 1'b0;
    o_ext_req   = 1'b0;
    o_ext_we    = 1'b0;
    o_ext_addr  = '0;
    o_ext_wdata = '0;
    case (r_state)
      ST_LOAD: begin
        o_ld_ready = i_acc_ext_sel;
        if (w_ld_fire) begin
          o_ext_req   = 1'b1;
          o_ext_we    = 1'b1;
          o_ext_addr  = w_ld_addr;
          o_ext_wdata = i_ld_data;
        end
      end
      ST_KICK, ST_WAIT_RUN: o_acc_start = 1'b1;
      ST_RD_REQ: begin
        if (i_acc_ext_sel) begin
          o_ext_req  = 1'b1;
          o_ext_addr = w_rd_addr;
        end
      end
      ST_RD_OUT: o_res_valid = 1'b1;
      ST_FINISH: o_job_done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt     <= '0;
      r_tcnt     <= '0;
      r_k        <= '0;
      r_res_data <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_start) begin
            r_wcnt  <= '0;
            r_tcnt  <= '0;
            r_k     <= '0;
            r_error <= 1'b0;
          end
        end
        ST_LOAD:      if (w_ld_fire) r_wcnt <= r_wcnt + WCNT_W'(1);
        ST_WAIT_RUN, ST_WAIT_DONE: begin
          r_tcnt <= r_tcnt + TCNT_W'(1);
          if (w_timeout) r_error <= 1'b1;
        end
        ST_RD_CAP:    r_res_data <= i_ext_rdata;
        ST_RD_OUT:    if (i_res_ready) r_k <= r_k + KCNT_W'(1);
        default: ;
      endcase
    end
  end

  assign o_error    = r_error;
  assign o_res_data = r_res_data;

endmodule
